// File: rtl/note_scheduler.sv
// Chart-driven scheduler: spawns due chart notes onto the lowest free dropper slot and tallies score/combo.
// Optional max_combo tracking is built only when SCHED_MAX_COMBO_EN is defined; otherwise max_combo reads 0.
module note_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int CHART_AW  = 6
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [7:0]             keycode,
    input  logic [7:0]             keycode_second,
    output logic [CHART_AW-1:0]    chart_addr,
    input  logic [15:0]            chart_data,
    output logic [NUM_SLOTS-1:0]   slot_spawn,
    output logic [2*NUM_SLOTS-1:0] slot_lane,
    input  logic [NUM_SLOTS-1:0]   slot_done,
    input  logic [NUM_SLOTS-1:0]   slot_hit,
    output logic                   playing,
    output logic                   game_over,
    output logic [15:0]            score,
    output logic [7:0]             combo,
    output logic [7:0]             max_combo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [11:0]            frame_cnt;
    logic                   wrapped;
    logic [NUM_SLOTS-1:0]   busy, busy_nxt, alloc, done_ok;
    logic                   start, key_start, key_quit, end_of_chart, due;
    logic [4:0]             hits, misses;
    logic [16:0]            score_sum;
    logic [8:0]             combo_sum;
    logic [15:0]            score_nxt;
    logic [7:0]             combo_nxt;
    logic                   unused_chart_bit;

    assign unused_chart_bit = chart_data[14];

    assign key_start    = (keycode == 8'h2c) || (keycode_second == 8'h2c);
    assign key_quit     = (keycode == 8'h01) || (keycode_second == 8'h01);
    assign done_ok      = slot_done & busy;
    assign end_of_chart = chart_data[15] | wrapped;
    assign due          = !end_of_chart && (chart_data[13:2] <= frame_cnt);
    assign busy_nxt     = (busy & ~done_ok) | alloc;
    assign playing      = (state == RUN);
    assign game_over    = (state == DONE);

    always_comb begin
        state_nxt = state;
        alloc     = '0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (key_start) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                // Scan downward so the lowest free index wins.
                if (due) begin
                    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                        if (!busy[i]) begin
                            alloc    = '0;
                            alloc[i] = 1'b1;
                        end
                    end
                end
                if (end_of_chart && ((busy & ~done_ok) == '0))
                    state_nxt = DONE;
            end
            DONE: begin
                if (key_quit)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hits   = '0;
        misses = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hits   = hits   + {4'b0, done_ok[i] &  slot_hit[i]};
            misses = misses + {4'b0, done_ok[i] & ~slot_hit[i]};
        end
        score_sum = {1'b0, score} + {12'b0, hits};
        combo_sum = {1'b0, combo} + {4'b0, hits};
        score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (misses != '0)
            combo_nxt = 8'h00;
        else
            combo_nxt = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end

    always_ff @(posedge frame_clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            chart_addr <= '0;
            frame_cnt  <= '0;
            wrapped    <= 1'b0;
            busy       <= '0;
            slot_spawn <= '0;
            slot_lane  <= '0;
            score      <= '0;
            combo      <= '0;
        end else begin
            slot_spawn <= alloc;
            if (start) begin
                chart_addr <= '0;
                frame_cnt  <= '0;
                wrapped    <= 1'b0;
                busy       <= '0;
                slot_lane  <= '0;
                score      <= '0;
                combo      <= '0;
            end else begin
                busy  <= busy_nxt;
                score <= score_nxt;
                combo <= combo_nxt;
                if (state == RUN && frame_cnt != 12'hFFF)
                    frame_cnt <= frame_cnt + 12'd1;
                if (alloc != '0) begin
                    chart_addr <= chart_addr + 1'b1;
                    if (chart_addr == '1)
                        wrapped <= 1'b1;
                end
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (alloc[i])
                        slot_lane[2*i +: 2] <= chart_data[1:0];
                end
            end
        end
    end

`ifdef SCHED_MAX_COMBO_EN
    always_ff @(posedge frame_clk) begin
        if (Reset || start)
            max_combo <= 8'h00;
        else if (combo_nxt > max_combo)
            max_combo <= combo_nxt;
    end
`else
    assign max_combo = 8'h00;
`endif

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: start/spawn timing, slot stall, score/combo, end of game, reset, saturation.
module tb_note_scheduler;

    localparam int NS = 4;
    localparam int AW = 9;
`ifdef SCHED_MAX_COMBO_EN
    localparam logic [7:0] MAXC5   = 8'd5;
    localparam logic [7:0] MAXC255 = 8'd255;
`else
    localparam logic [7:0] MAXC5   = 8'd0;
    localparam logic [7:0] MAXC255 = 8'd0;
`endif

    logic            frame_clk;
    logic            Reset;
    logic [7:0]      keycode, keycode_second;
    logic [AW-1:0]   chart_addr;
    logic [15:0]     chart_data;
    logic [NS-1:0]   slot_spawn, slot_done, slot_hit;
    logic [2*NS-1:0] slot_lane;
    logic            playing, game_over;
    logic [15:0]     score;
    logic [7:0]      combo, max_combo;

    logic [15:0] rom [2**AW];
    int tests = 0;
    int fails = 0;

    assign chart_data = rom[chart_addr];

    note_scheduler #(.NUM_SLOTS(NS), .CHART_AW(AW)) dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .keycode(keycode), .keycode_second(keycode_second),
        .chart_addr(chart_addr), .chart_data(chart_data),
        .slot_spawn(slot_spawn), .slot_lane(slot_lane),
        .slot_done(slot_done), .slot_hit(slot_hit),
        .playing(playing), .game_over(game_over),
        .score(score), .combo(combo), .max_combo(max_combo)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_done;
        int cyc;
        Reset = 1'b1; keycode = 8'h00; keycode_second = 8'h00;
        slot_done = '0; slot_hit = '0;
        for (int i = 0; i < 2**AW; i++) rom[i] = 16'h8000;
        tick(); tick();
        chk("rst_playing", playing, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_spawn", slot_spawn, 0);
        chk("rst_lane", slot_lane, 0);
        chk("rst_addr", chart_addr, 0);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_max", max_combo, 0);
        Reset = 1'b0;
        tick();
        chk("idle_playing", playing, 0);

        // Game 1: two notes at frame 3
        rom[0] = 16'h000D; rom[1] = 16'h000E; rom[2] = 16'h8000;
        keycode_second = 8'h2c;
        tick();
        keycode_second = 8'h00;
        chk("g1_playing", playing, 1);
        tick(); tick(); tick();
        chk("g1_no_early_spawn", slot_spawn, 0);
        tick();
        chk("g1_spawn0", slot_spawn, 4'b0001);
        chk("g1_lane0", slot_lane, 8'h01);
        chk("g1_addr1", chart_addr, 1);
        tick();
        chk("g1_spawn1", slot_spawn, 4'b0010);
        chk("g1_lane1", slot_lane, 8'h09);
        slot_done = 4'b0001; slot_hit = 4'b0001;
        tick();
        chk("g1_spawn_idle", slot_spawn, 0);
        chk("g1_score1", score, 1);
        chk("g1_combo1", combo, 1);
        chk("g1_not_over", game_over, 0);
        slot_done = 4'b0010; slot_hit = 4'b0010;
        tick();
        slot_done = '0; slot_hit = '0;
        chk("g1_over", game_over, 1);
        chk("g1_score2", score, 2);
        keycode = 8'h2c;
        tick(); tick();
        chk("g1_start_ignored_done", game_over, 1);
        keycode = 8'h01;
        tick();
        keycode = 8'h00;
        chk("g1_idle_over", game_over, 0);
        chk("g1_idle_playing", playing, 0);
        chk("g1_score_kept", score, 2);

        // Game 2: seven notes at frame 0 on four slots
        rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003; rom[3] = 16'h0000;
        rom[4] = 16'h0003; rom[5] = 16'h0002; rom[6] = 16'h0001; rom[7] = 16'h8000;
        keycode = 8'h2c;
        tick();
        keycode = 8'h00;
        chk("g2_score_clr", score, 0);
        chk("g2_lane_clr", slot_lane, 0);
        tick(); tick(); tick(); tick();
        chk("g2_spawn3", slot_spawn, 4'b1000);
        chk("g2_addr4", chart_addr, 4);
        tick();
        chk("g2_stall_spawn", slot_spawn, 0);
        chk("g2_stall_addr", chart_addr, 4);
        slot_done = 4'b0001; slot_hit = 4'b0001;
        tick();
        slot_done = '0; slot_hit = '0;
        chk("g2_not_same_cycle", slot_spawn, 0);
        chk("g2_score1", score, 1);
        tick();
        chk("g2_respawn0", slot_spawn, 4'b0001);
        chk("g2_lanes_a", slot_lane, 8'h3B);
        chk("g2_addr5", chart_addr, 5);
        slot_done = 4'b1100; slot_hit = 4'b1100;
        tick();
        slot_done = '0; slot_hit = '0;
        chk("g2_score3", score, 3);
        chk("g2_combo3", combo, 3);
        tick();
        chk("g2_spawn2", slot_spawn, 4'b0100);
        tick();
        chk("g2_spawn3b", slot_spawn, 4'b1000);
        chk("g2_lanes_b", slot_lane, 8'h6B);
        chk("g2_addr7", chart_addr, 7);
        slot_done = 4'b1100; slot_hit = 4'b1100;
        tick();
        chk("g2_combo5", combo, 5);
        chk("g2_score5", score, 5);
        chk("g2_max5a", max_combo, MAXC5);
        slot_done = 4'b0011; slot_hit = 4'b0001;
        tick();
        slot_done = '0; slot_hit = '0;
        chk("g2_score6", score, 6);
        chk("g2_miss_combo", combo, 0);
        chk("g2_max5b", max_combo, MAXC5);
        chk("g2_over", game_over, 1);
        keycode_second = 8'h01;
        tick();
        keycode_second = 8'h00;
        chk("g2_idle", game_over, 0);

        // Game 3: reset with three busy slots
        rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003; rom[3] = 16'h8000;
        keycode = 8'h2c;
        tick();
        keycode = 8'h00;
        tick(); tick(); tick();
        chk("g3_spawn2", slot_spawn, 4'b0100);
        Reset = 1'b1;
        slot_done = 4'b0001; slot_hit = 4'b0001;
        tick();
        Reset = 1'b0;
        chk("g3_rst_playing", playing, 0);
        chk("g3_rst_spawn", slot_spawn, 0);
        chk("g3_rst_lane", slot_lane, 0);
        chk("g3_rst_addr", chart_addr, 0);
        chk("g3_rst_score", score, 0);
        slot_done = 4'b0111; slot_hit = 4'b0111;
        tick();
        slot_done = '0; slot_hit = '0;
        chk("g3_done_ignored_score", score, 0);
        chk("g3_done_ignored_combo", combo, 0);
        chk("g3_idle_over", game_over, 0);

        // Game 4: 300 consecutive hits
        for (int i = 0; i < 300; i++) rom[i] = 16'(i % 4);
        rom[300] = 16'h8000;
        keycode = 8'h2c;
        tick();
        keycode = 8'h00;
        n_done = 0;
        cyc = 0;
        while (n_done < 300 && cyc < 3000) begin
            slot_done = slot_spawn;
            slot_hit  = slot_spawn;
            n_done += $countones(slot_spawn);
            tick();
            cyc++;
        end
        slot_done = '0; slot_hit = '0;
        chk("g4_done_count", n_done, 300);
        chk("g4_score300", score, 300);
        chk("g4_combo_sat", combo, 255);
        chk("g4_max_sat", max_combo, MAXC255);
        chk("g4_over", game_over, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
